letc_core_muldiv: RTL

Parametrised iterative multiply/divide unit for the RV32M extension. It sits beside the single-cycle integer ALU in the LETC core execute stage. It accepts one request at a time over a valid/ready handshake and returns one result over a valid/ready handshake. It supports configurable datapath width, bits retired per cycle, a divide-by-zero/overflow fast path, and pipeline flush.

---
 rtl/letc_core_muldiv.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/letc_core_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide over magnitudes,
// STEP bits per cycle, with a divide-by-zero/overflow fast path and flush support.
module letc_core_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [2*WIDTH-1:0] req_operands,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [WIDTH-1:0]   resp_result
);

  localparam int unsigned N  = WIDTH / STEP;
  localparam int unsigned CW = $clog2(N + 1);

  localparam logic [2:0] OpMul    = 3'd0;
  localparam logic [2:0] OpMulh   = 3'd1;
  localparam logic [2:0] OpMulhsu = 3'd2;
  localparam logic [2:0] OpDiv    = 3'd4;
  localparam logic [2:0] OpRem    = 3'd6;

  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StBusy, StFixup, StDone} state_e;

  state_e           state_q;
  logic             req_ready_q;
  logic             resp_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt_q;
  logic [2:0]       op_q;
  logic             neg_q;
  logic             rem_neg_q;
  // hi: product high half / partial remainder; lo: multiplier / dividend-then-quotient
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opnd_q;

  // Request decode
  logic [WIDTH-1:0] rs1, rs2;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             fast;
  logic [WIDTH-1:0] fast_result;

  always_comb begin
    logic a_signed, b_signed, ovf;
    rs1      = req_operands[WIDTH-1:0];
    rs2      = req_operands[2*WIDTH-1:WIDTH];
    a_signed = (req_op == OpMulh) || (req_op == OpMulhsu) || (req_op == OpDiv) ||
               (req_op == OpRem);
    b_signed = (req_op == OpMulh) || (req_op == OpDiv) || (req_op == OpRem);
    a_neg    = a_signed && rs1[WIDTH-1];
    b_neg    = b_signed && rs2[WIDTH-1];
    a_mag    = a_neg ? -rs1 : rs1;
    b_mag    = b_neg ? -rs2 : rs2;
    ovf      = ((req_op == OpDiv) || (req_op == OpRem)) && (rs1 == MinNeg) && (rs2 == '1);
    fast     = req_op[2] && ((rs2 == '0) || ovf);
    // op[1] distinguishes REM/REMU from DIV/DIVU
    if (rs2 == '0) begin
      fast_result = req_op[1] ? rs1 : '1;
    end else begin
      fast_result = req_op[1] ? '0 : rs1;
    end
  end

  // One iteration of either datapath
  logic [WIDTH+STEP-1:0] mul_partial;
  logic [2*WIDTH-1:0]    mul_next;
  logic [WIDTH:0]        div_rem;
  logic [WIDTH-1:0]      div_quo;
  logic [WIDTH-1:0]      iter_hi, iter_lo;

  always_comb begin
    mul_partial = {{STEP{1'b0}}, hi_q} +
                  ({{STEP{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, lo_q[STEP-1:0]});
    mul_next    = (2*WIDTH)'({mul_partial, lo_q} >> STEP);

    div_rem = {1'b0, hi_q};
    div_quo = lo_q;
    for (int i = 0; i < int'(STEP); i++) begin
      div_rem = {div_rem[WIDTH-1:0], div_quo[WIDTH-1]};
      div_quo = {div_quo[WIDTH-2:0], 1'b0};
      if (div_rem >= {1'b0, opnd_q}) begin
        div_rem    = div_rem - {1'b0, opnd_q};
        div_quo[0] = 1'b1;
      end
    end

    if (op_q[2]) begin
      iter_hi = div_rem[WIDTH-1:0];
      iter_lo = div_quo;
    end else begin
      iter_hi = mul_next[2*WIDTH-1:WIDTH];
      iter_lo = mul_next[WIDTH-1:0];
    end
  end

  // Sign correction and half/quotient/remainder select
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, fixup_result;

  always_comb begin
    prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_fix  = neg_q ? -lo_q : lo_q;
    rem_fix  = rem_neg_q ? -hi_q : hi_q;
    if (op_q[2]) begin
      fixup_result = op_q[1] ? rem_fix : quo_fix;
    end else if (op_q == OpMul) begin
      fixup_result = prod_fix[WIDTH-1:0];
    end else begin
      fixup_result = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      result_q     <= '0;
      cnt_q        <= '0;
      op_q         <= '0;
      neg_q        <= 1'b0;
      rem_neg_q    <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
      opnd_q       <= '0;
    end else if (flush) begin
      state_q      <= StIdle;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid && req_ready_q) begin
            op_q        <= req_op;
            neg_q       <= a_neg ^ b_neg;
            rem_neg_q   <= a_neg;
            hi_q        <= '0;
            lo_q        <= req_op[2] ? a_mag : b_mag;
            opnd_q      <= req_op[2] ? b_mag : a_mag;
            req_ready_q <= 1'b0;
            if (fast) begin
              result_q     <= fast_result;
              resp_valid_q <= 1'b1;
              state_q      <= StDone;
            end else begin
              cnt_q   <= CW'(N);
              state_q <= StBusy;
            end
          end
        end
        StBusy: begin
          hi_q  <= iter_hi;
          lo_q  <= iter_lo;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q <= StFixup;
          end
        end
        StFixup: begin
          result_q     <= fixup_result;
          resp_valid_q <= 1'b1;
          state_q      <= StDone;
        end
        StDone: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_result = result_q;

endmodule
